poly_voice_alloc: RTL
=====================

Name: poly_voice_alloc

Overview:
Voice allocator sitting between the MIDI receiver and the 8-voice wave generator bank. It replaces the daisy-chained ready wiring with a central scheduler. Each note-on is assigned to one voice: retrigger, then free, then releasing, then steal least-recently-used. Each note-off is routed to the voice holding that note. Outputs are a shared message bus and a one-hot per-voice strobe.

Parameters:
NUM_VOICES, 8, number of wave generator voices (power of 2, 2..16)
IDX_W, 3, voice index width, equal to log2(NUM_VOICES)

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
MIDI_MSG  in  24  [23:16] status, [15:8] note, [7:0] velocity
MIDI_MSG_RDY  in  1  one-cycle strobe, MIDI_MSG valid
VOICE_BUSY  in  NUM_VOICES  per-voice envelope not yet idle (release tail sounding)
VOICE_MSG  out  24  message forwarded to voices
VOICE_MSG_RDY  out  NUM_VOICES  one-hot (or all-ones broadcast) strobe, valid with VOICE_MSG
NOTE_ON_LED  out  NUM_VOICES  per-voice "key held" flag
ALLOC_BUSY  out  1  high while not in IDLE
MSG_DROP  out  1  one-cycle pulse when MIDI_MSG_RDY is seen while ALLOC_BUSY is high

Behaviour:
- Reset (async, RST_N=0): all outputs 0; state IDLE; per-voice active=0 and note=0; LRU rank[i]=i. Higher rank means older. Ranks stay a permutation of 0..NUM_VOICES-1 at all times.
- Classification:
  - note-on: status[7:4]=4'h9 and velocity!=0.
  - note-off: status[7:4]=4'h8, or 4'h9 with velocity=0.
  - anything else: broadcast.
- FSM states: IDLE, DECIDE, STEAL_OFF, ISSUE.
- IDLE: on MIDI_MSG_RDY, latch the message and go to DECIDE. ALLOC_BUSY rises the next cycle.
- DECIDE, target selection in priority order:
  - note-on, first match wins:
    (a) active voice with the same note (retrigger);
    (b) lowest-index voice with active=0 and VOICE_BUSY=0;
    (c) voice with active=0 and VOICE_BUSY=1 and highest rank;
    (d) active voice with highest rank, flagged as steal.
  - note-off: lowest-index active voice with the same note; if none, return to IDLE with no output.
  - broadcast: target = all voices.
  - Next state is STEAL_OFF if steal, else ISSUE.
- STEAL_OFF: drive VOICE_MSG = {8'h80 | channel, victim note, 8'h00} with a one-hot strobe to the victim for 1 cycle. Then go to ISSUE.
- ISSUE: drive the latched message with a strobe to the target for exactly 1 cycle, then return to IDLE.
  - note-on: target active=1, note=latched note, rank[target]=0; every voice whose rank was below the target's old rank increments by 1.
  - note-off: active=0; ranks unchanged.
  - Bookkeeping updates take effect the cycle after ISSUE.
- Latency, RDY sample cycle = T:
  - normal: strobe at T+2, ALLOC_BUSY high T+1..T+2, next message accepted at T+3.
  - steal: note-off at T+2, note-on at T+3, ALLOC_BUSY high T+1..T+3.
- VOICE_MSG holds its last value when no strobe is active. VOICE_MSG_RDY is 0 outside STEAL_OFF/ISSUE.
- MIDI_MSG_RDY while ALLOC_BUSY=1: message discarded, MSG_DROP pulses the next cycle, no state change. A drop in ISSUE's cycle is still a drop.
- NOTE_ON_LED[i] = active[i], registered.
- Retrigger leaves the voice on the same index and sets its rank to 0.
- Reset asserted mid-operation aborts immediately. No partial strobe completes after RST_N releases.

Decomposition:
- Shared package poly_pkg:
  - MIDI_NOTE_ON=4'h9, MIDI_NOTE_OFF=4'h8;
  - field slices STATUS/NOTE/VEL;
  - FSM state enum;
  - NUM_VOICES default.
- One sub-module, poly_voice_select: purely combinational.
  - Inputs: active, note array, rank array, VOICE_BUSY, request note and type.
  - Outputs: target index, found, steal.
  - Instantiated once; its result is registered at DECIDE.

Test Plan:
1. Reset, then note-on 90 3C 40 → VOICE_MSG=90 3C 40 at T+2, VOICE_MSG_RDY=8'h01, NOTE_ON_LED=8'h01, MSG_DROP=0.
2. Note-ons for notes 3C..43 (8 msgs, 3-cycle spacing) → voices 0..7 in order, NOTE_ON_LED=8'hFF. Ninth note-on 48 → strobe 8'h01 with 80 3C 00 at T+2, then 8'h01 with 90 48 xx at T+3.
3. Voices 0,1 active; note-off 80 3C 00 → strobe 8'h01, LED=8'h02. Then note-on 3E while VOICE_BUSY=8'h01 → voice 2 chosen, not voice 0.
4. All voices inactive and VOICE_BUSY=8'hFF after sequential on/off of voices 0..7 → next note-on goes to voice 0 (highest rank), no STEAL_OFF.
5. Note-on followed by a second MIDI_MSG_RDY 1 cycle later → MSG_DROP pulse, only the first message forwarded. Note-off for unheld note 50 → no strobe. Control change B0 07 64 → VOICE_MSG_RDY=8'hFF for one cycle.
6. Assert RST_N low during STEAL_OFF → all outputs 0 immediately, LED=0, and the pending note-on is never issued after release.

Source files
------------

// File: rtl/poly_pkg.sv
// Shared definitions for the polyphonic voice allocator: MIDI field
// layout, message classification and the allocator FSM state encoding.
package poly_pkg;

    localparam int NUM_VOICES_DEF = 8;

    localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
    localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;

    // 24-bit message layout: [23:16] status, [15:8] note, [7:0] velocity
    localparam int STATUS_MSB = 23;
    localparam int STATUS_LSB = 16;
    localparam int NOTE_MSB   = 15;
    localparam int NOTE_LSB   = 8;
    localparam int VEL_MSB    = 7;
    localparam int VEL_LSB    = 0;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DECIDE    = 2'd1,
        S_STEAL_OFF = 2'd2,
        S_ISSUE     = 2'd3
    } alloc_state_e;

    typedef enum logic [1:0] {
        K_NOTE_ON  = 2'd0,
        K_NOTE_OFF = 2'd1,
        K_BCAST    = 2'd2
    } msg_kind_e;

    function automatic logic [7:0] msg_status(input logic [23:0] m);
        return m[STATUS_MSB:STATUS_LSB];
    endfunction

    function automatic logic [7:0] msg_note(input logic [23:0] m);
        return m[NOTE_MSB:NOTE_LSB];
    endfunction

    function automatic logic [7:0] msg_vel(input logic [23:0] m);
        return m[VEL_MSB:VEL_LSB];
    endfunction

    // A note-on with velocity 0 is a note-off by MIDI running-status habit
    function automatic msg_kind_e classify(input logic [23:0] m);
        logic [7:0] st;
        st = msg_status(m);
        if (st[7:4] == MIDI_NOTE_ON && msg_vel(m) != 8'h00) return K_NOTE_ON;
        if (st[7:4] == MIDI_NOTE_OFF || st[7:4] == MIDI_NOTE_ON) return K_NOTE_OFF;
        return K_BCAST;
    endfunction

endpackage

// File: rtl/poly_voice_select.sv
// Combinational voice picker. For note-on: retrigger, then lowest free,
// then oldest releasing, then oldest active (steal). For note-off: the
// lowest-index active voice holding the note.
module poly_voice_select
    import poly_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int IDX_W      = $clog2(NUM_VOICES)
) (
    input  logic [NUM_VOICES-1:0] active,
    input  logic [7:0]            notes [NUM_VOICES],
    input  logic [IDX_W-1:0]      ranks [NUM_VOICES],
    input  logic [NUM_VOICES-1:0] voice_busy,
    input  logic [7:0]            req_note,
    input  logic                  req_on,
    output logic [IDX_W-1:0]      target,
    output logic                  found,
    output logic                  steal
);

    logic             hit_re, hit_free, hit_rel, hit_act;
    logic [IDX_W-1:0] idx_re, idx_free, idx_rel, idx_act;
    logic [IDX_W-1:0] rank_rel, rank_act;

    // Scan all voices for each candidate class independently
    always_comb begin
        hit_re   = 1'b0;
        hit_free = 1'b0;
        hit_rel  = 1'b0;
        hit_act  = 1'b0;
        idx_re   = '0;
        idx_free = '0;
        idx_rel  = '0;
        idx_act  = '0;
        rank_rel = '0;
        rank_act = '0;
        // Descending scan so the lowest index is the last one written
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (active[i] && notes[i] == req_note) begin
                hit_re = 1'b1;
                idx_re = IDX_W'(i);
            end
            if (!active[i] && !voice_busy[i]) begin
                hit_free = 1'b1;
                idx_free = IDX_W'(i);
            end
        end
        // Ranks are a permutation, so the oldest candidate is unique
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!active[i] && voice_busy[i] && (!hit_rel || ranks[i] > rank_rel)) begin
                hit_rel  = 1'b1;
                idx_rel  = IDX_W'(i);
                rank_rel = ranks[i];
            end
            if (active[i] && (!hit_act || ranks[i] > rank_act)) begin
                hit_act  = 1'b1;
                idx_act  = IDX_W'(i);
                rank_act = ranks[i];
            end
        end
    end

    // Apply the priority order to the candidate classes
    always_comb begin
        target = '0;
        found  = 1'b0;
        steal  = 1'b0;
        if (hit_re) begin
            target = idx_re;
            found  = 1'b1;
        end else if (req_on && hit_free) begin
            target = idx_free;
            found  = 1'b1;
        end else if (req_on && hit_rel) begin
            target = idx_rel;
            found  = 1'b1;
        end else if (req_on && hit_act) begin
            target = idx_act;
            found  = 1'b1;
            steal  = 1'b1;
        end
    end

endmodule

// File: rtl/poly_voice_alloc.sv
// Central voice scheduler between the MIDI receiver and the voice bank.
// Handshake: midi_msg_rdy is a one-cycle strobe with no back-pressure; a
// strobe seen while alloc_busy is high is discarded and flagged on
// msg_drop the following cycle. voice_msg_rdy is a one-cycle strobe
// (one-hot, or all ones for broadcast) qualifying voice_msg; voices must
// accept it in that cycle.
module poly_voice_alloc
    import poly_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int IDX_W      = $clog2(NUM_VOICES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [23:0]           midi_msg,
    input  logic                  midi_msg_rdy,
    input  logic [NUM_VOICES-1:0] voice_busy,
    output logic [23:0]           voice_msg,
    output logic [NUM_VOICES-1:0] voice_msg_rdy,
    output logic [NUM_VOICES-1:0] note_on_led,
    output logic                  alloc_busy,
    output logic                  msg_drop,
    output alloc_state_e          state_dbg
);

    alloc_state_e          state;
    logic [23:0]           msg_q;
    msg_kind_e             kind_q;
    logic [IDX_W-1:0]      tgt_q;
    logic [NUM_VOICES-1:0] active;
    logic [7:0]            notes [NUM_VOICES];
    logic [IDX_W-1:0]      ranks [NUM_VOICES];

    logic [IDX_W-1:0]      sel_target;
    logic                  sel_found;
    logic                  sel_steal;
    logic [NUM_VOICES-1:0] sel_onehot;
    logic [NUM_VOICES-1:0] tgt_onehot;

    poly_voice_select #(
        .NUM_VOICES (NUM_VOICES),
        .IDX_W      (IDX_W)
    ) u_select (
        .active     (active),
        .notes      (notes),
        .ranks      (ranks),
        .voice_busy (voice_busy),
        .req_note   (msg_note(msg_q)),
        .req_on     (kind_q == K_NOTE_ON),
        .target     (sel_target),
        .found      (sel_found),
        .steal      (sel_steal)
    );

    assign sel_onehot  = {{(NUM_VOICES-1){1'b0}}, 1'b1} << sel_target;
    assign tgt_onehot  = {{(NUM_VOICES-1){1'b0}}, 1'b1} << tgt_q;
    assign note_on_led = active;
    assign state_dbg   = state;

    // Allocator FSM with registered outputs and per-voice bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            msg_q         <= '0;
            kind_q        <= K_NOTE_ON;
            tgt_q         <= '0;
            active        <= '0;
            voice_msg     <= '0;
            voice_msg_rdy <= '0;
            alloc_busy    <= 1'b0;
            msg_drop      <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                notes[i] <= '0;
                ranks[i] <= IDX_W'(i);
            end
        end else begin
            msg_drop      <= midi_msg_rdy && (state != S_IDLE);
            voice_msg_rdy <= '0;
            case (state)
                S_IDLE: begin
                    if (midi_msg_rdy) begin
                        msg_q      <= midi_msg;
                        kind_q     <= classify(midi_msg);
                        alloc_busy <= 1'b1;
                        state      <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    tgt_q <= sel_target;
                    if (kind_q == K_BCAST) begin
                        voice_msg     <= msg_q;
                        voice_msg_rdy <= '1;
                        state         <= S_ISSUE;
                    end else if (!sel_found) begin
                        // Note-off for a note nobody holds: nothing to send
                        alloc_busy <= 1'b0;
                        state      <= S_IDLE;
                    end else if (sel_steal) begin
                        voice_msg     <= {MIDI_NOTE_OFF, msg_q[19:16], notes[sel_target], 8'h00};
                        voice_msg_rdy <= sel_onehot;
                        state         <= S_STEAL_OFF;
                    end else begin
                        voice_msg     <= msg_q;
                        voice_msg_rdy <= sel_onehot;
                        state         <= S_ISSUE;
                    end
                end
                S_STEAL_OFF: begin
                    voice_msg     <= msg_q;
                    voice_msg_rdy <= tgt_onehot;
                    state         <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (kind_q == K_NOTE_ON) begin
                        active[tgt_q] <= 1'b1;
                        notes[tgt_q]  <= msg_note(msg_q);
                        // Move-to-front: target becomes youngest, younger ones age
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (IDX_W'(i) == tgt_q) begin
                                ranks[i] <= '0;
                            end else if (ranks[i] < ranks[tgt_q]) begin
                                ranks[i] <= ranks[i] + 1'b1;
                            end
                        end
                    end else if (kind_q == K_NOTE_OFF) begin
                        active[tgt_q] <= 1'b0;
                    end
                    alloc_busy <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    alloc_busy <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
